// File: rtl/int_issue_queue_if.sv
// Dispatch/writeback/execute-side bundle of the integer issue queue.
// master is the environment around the queue, slave is the queue.
interface int_issue_queue_if #(
    parameter int ROB_W     = 6,
    parameter int PRF_W     = 7,
    parameter int PAYLOAD_W = 64
);
    logic                 flush_valid;

    logic                 enq0_valid;
    logic [ROB_W-1:0]     enq0_robid;
    logic [PRF_W-1:0]     enq0_T;
    logic [PRF_W-1:0]     enq0_src1;
    logic [PRF_W-1:0]     enq0_src2;
    logic                 enq0_src1_busy;
    logic                 enq0_src2_busy;
    logic [PAYLOAD_W-1:0] enq0_payload;

    logic                 enq1_valid;
    logic [ROB_W-1:0]     enq1_robid;
    logic [PRF_W-1:0]     enq1_T;
    logic [PRF_W-1:0]     enq1_src1;
    logic [PRF_W-1:0]     enq1_src2;
    logic                 enq1_src1_busy;
    logic                 enq1_src2_busy;
    logic [PAYLOAD_W-1:0] enq1_payload;

    logic                 wb0_valid;
    logic [PRF_W-1:0]     wb0_tag;
    logic                 wb1_valid;
    logic [PRF_W-1:0]     wb1_tag;

    logic                 iss_valid;
    logic                 iss_ready;
    logic [ROB_W-1:0]     iss_robid;
    logic [PRF_W-1:0]     iss_T;
    logic [PRF_W-1:0]     iss_src1;
    logic [PRF_W-1:0]     iss_src2;
    logic [PAYLOAD_W-1:0] iss_payload;

    logic [1:0]           intisq_left;
    logic                 overflow_err;

    modport master (
        output flush_valid,
        output enq0_valid, enq0_robid, enq0_T, enq0_src1, enq0_src2,
        output enq0_src1_busy, enq0_src2_busy, enq0_payload,
        output enq1_valid, enq1_robid, enq1_T, enq1_src1, enq1_src2,
        output enq1_src1_busy, enq1_src2_busy, enq1_payload,
        output wb0_valid, wb0_tag, wb1_valid, wb1_tag,
        output iss_ready,
        input  iss_valid, iss_robid, iss_T, iss_src1, iss_src2, iss_payload,
        input  intisq_left, overflow_err
    );

    modport slave (
        input  flush_valid,
        input  enq0_valid, enq0_robid, enq0_T, enq0_src1, enq0_src2,
        input  enq0_src1_busy, enq0_src2_busy, enq0_payload,
        input  enq1_valid, enq1_robid, enq1_T, enq1_src1, enq1_src2,
        input  enq1_src1_busy, enq1_src2_busy, enq1_payload,
        input  wb0_valid, wb0_tag, wb1_valid, wb1_tag,
        input  iss_ready,
        output iss_valid, iss_robid, iss_T, iss_src1, iss_src2, iss_payload,
        output intisq_left, overflow_err
    );
endinterface

// File: rtl/int_issue_queue.sv
// Integer issue queue: dual enqueue, tag wakeup, oldest-ready select via age matrix.
// Optional INTISQ_WAKEUP_BYPASS_EN: same-cycle writeback tags also count as ready.
module int_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int ROB_W     = 6,
    parameter int PRF_W     = 7,
    parameter int PAYLOAD_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    int_issue_queue_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic [ROB_W-1:0]     robid;
        logic [PRF_W-1:0]     t;
        logic [PRF_W-1:0]     src1;
        logic [PRF_W-1:0]     src2;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] busy1_q, busy1_d;
    logic [DEPTH-1:0] busy2_q, busy2_d;
    ent_t             ent_q   [DEPTH];
    ent_t             ent_d   [DEPTH];
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic             ovf_q, ovf_d;

    logic [DEPTH-1:0] hit1, hit2, rdy, sel, iss_clr;
    logic             e0_hit1, e0_hit2, e1_hit1, e1_hit2;
    logic             iss_v;
    ent_t             iss_e, enq0_e, enq1_e;

    logic [IW-1:0]    f0, f1, slot0, slot1;
    logic [CW-1:0]    free_cnt, need;
    logic             ovf_now, do_enq, wr0, wr1;
    logic [DEPTH-1:0] oh0;

    // Writeback tag match against every stored source and both enqueue ports
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i] = (bus.wb0_valid && bus.wb0_tag == ent_q[i].src1) ||
                      (bus.wb1_valid && bus.wb1_tag == ent_q[i].src1);
            hit2[i] = (bus.wb0_valid && bus.wb0_tag == ent_q[i].src2) ||
                      (bus.wb1_valid && bus.wb1_tag == ent_q[i].src2);
        end
        e0_hit1 = (bus.wb0_valid && bus.wb0_tag == bus.enq0_src1) ||
                  (bus.wb1_valid && bus.wb1_tag == bus.enq0_src1);
        e0_hit2 = (bus.wb0_valid && bus.wb0_tag == bus.enq0_src2) ||
                  (bus.wb1_valid && bus.wb1_tag == bus.enq0_src2);
        e1_hit1 = (bus.wb0_valid && bus.wb0_tag == bus.enq1_src1) ||
                  (bus.wb1_valid && bus.wb1_tag == bus.enq1_src1);
        e1_hit2 = (bus.wb0_valid && bus.wb0_tag == bus.enq1_src2) ||
                  (bus.wb1_valid && bus.wb1_tag == bus.enq1_src2);
    end

`ifdef INTISQ_WAKEUP_BYPASS_EN
    assign rdy = valid_q & ~(busy1_q & ~hit1) & ~(busy2_q & ~hit2);
`else
    assign rdy = valid_q & ~busy1_q & ~busy2_q;
`endif

    // An entry wins when no ready entry is older than it
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = rdy[i] & ~|(older_q[i] & rdy);
        end
    end

    assign iss_v   = (|rdy) & ~bus.flush_valid;
    assign iss_clr = (iss_v && bus.iss_ready) ? sel : '0;

    always_comb begin
        iss_e = ent_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                iss_e = ent_q[i];
            end
        end
    end

    assign bus.iss_valid   = iss_v;
    assign bus.iss_robid   = iss_e.robid;
    assign bus.iss_T       = iss_e.t;
    assign bus.iss_src1    = iss_e.src1;
    assign bus.iss_src2    = iss_e.src2;
    assign bus.iss_payload = iss_e.payload;

    // Lowest and second-lowest free slots, from pre-edge state only
    always_comb begin
        logic got0, got1;
        got0     = 1'b0;
        got1     = 1'b0;
        f0       = '0;
        f1       = '0;
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i]) begin
                free_cnt = free_cnt + CW'(1);
                if (!got0) begin
                    f0   = IW'(i);
                    got0 = 1'b1;
                end else if (!got1) begin
                    f1   = IW'(i);
                    got1 = 1'b1;
                end
            end
        end
    end

    assign need    = CW'(bus.enq0_valid) + CW'(bus.enq1_valid);
    assign ovf_now = ~bus.flush_valid & (need > free_cnt);
    assign do_enq  = ~bus.flush_valid & ~ovf_now;
    assign wr0     = do_enq & bus.enq0_valid;
    assign wr1     = do_enq & bus.enq1_valid;
    assign slot0   = f0;
    assign slot1   = bus.enq0_valid ? f1 : f0;
    assign oh0     = wr0 ? (DEPTH'(1) << slot0) : '0;

    assign bus.intisq_left  = (free_cnt >= CW'(2)) ? 2'd2 : free_cnt[1:0];
    assign bus.overflow_err = ovf_q;

    assign enq0_e = '{robid: bus.enq0_robid, t: bus.enq0_T,
                      src1: bus.enq0_src1, src2: bus.enq0_src2,
                      payload: bus.enq0_payload};
    assign enq1_e = '{robid: bus.enq1_robid, t: bus.enq1_T,
                      src1: bus.enq1_src1, src2: bus.enq1_src2,
                      payload: bus.enq1_payload};

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        busy1_d = busy1_q & ~hit1;
        busy2_d = busy2_q & ~hit2;
        older_d = older_q;
        ovf_d   = ovf_q | ovf_now;
        if (bus.flush_valid) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_d[i] = '0;
            end
        end else begin
            valid_d = valid_q & ~iss_clr;
            for (int i = 0; i < DEPTH; i++) begin
                older_d[i] = older_q[i] & ~iss_clr;
                if (iss_clr[i]) begin
                    older_d[i] = '0;
                end
            end
            if (wr0) begin
                valid_d[slot0] = 1'b1;
                ent_d[slot0]   = enq0_e;
                busy1_d[slot0] = bus.enq0_src1_busy & ~e0_hit1;
                busy2_d[slot0] = bus.enq0_src2_busy & ~e0_hit2;
                older_d[slot0] = valid_q & ~iss_clr;
            end
            // enq1 is younger than everything including enq0
            if (wr1) begin
                valid_d[slot1] = 1'b1;
                ent_d[slot1]   = enq1_e;
                busy1_d[slot1] = bus.enq1_src1_busy & ~e1_hit1;
                busy2_d[slot1] = bus.enq1_src2_busy & ~e1_hit2;
                older_d[slot1] = (valid_q & ~iss_clr) | oh0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            busy1_q <= '0;
            busy2_q <= '0;
            ent_q   <= '{default: '0};
            older_q <= '{default: '0};
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            busy1_q <= busy1_d;
            busy2_q <= busy2_d;
            ent_q   <= ent_d;
            older_q <= older_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed vector table, then randomized traffic
// against an age-ordered queue model.
module tb_int_issue_queue;
    localparam int DEPTH = 8;
    localparam int ROB_W = 6;
    localparam int PRF_W = 7;
    localparam int PAYLOAD_W = 64;
`ifdef INTISQ_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    int_issue_queue_if #(.ROB_W(ROB_W), .PRF_W(PRF_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    int_issue_queue #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .PRF_W(PRF_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.flush_valid = 0;
        bus.enq0_valid = 0; bus.enq0_robid = '0; bus.enq0_T = '0;
        bus.enq0_src1 = '0; bus.enq0_src2 = '0;
        bus.enq0_src1_busy = 0; bus.enq0_src2_busy = 0; bus.enq0_payload = '0;
        bus.enq1_valid = 0; bus.enq1_robid = '0; bus.enq1_T = '0;
        bus.enq1_src1 = '0; bus.enq1_src2 = '0;
        bus.enq1_src1_busy = 0; bus.enq1_src2_busy = 0; bus.enq1_payload = '0;
        bus.wb0_valid = 0; bus.wb0_tag = '0;
        bus.wb1_valid = 0; bus.wb1_tag = '0;
        bus.iss_ready = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic fl, rdy;
        logic e0v; logic [ROB_W-1:0] r0; logic [PRF_W-1:0] a0, c0; logic ab0, cb0;
        logic e1v; logic [ROB_W-1:0] r1; logic [PRF_W-1:0] a1, c1; logic ab1, cb1;
        logic w0v; logic [PRF_W-1:0] w0;
        logic w1v; logic [PRF_W-1:0] w1;
        logic xv; logic [ROB_W-1:0] xr; logic [1:0] xl; logic xo;
    } vec_t;

    function automatic vec_t rw(logic rdy, logic xv, int xr, int xl, logic xo);
        vec_t r;
        r = '{default: '0};
        r.rdy = rdy; r.xv = xv; r.xr = ROB_W'(xr); r.xl = 2'(xl); r.xo = xo;
        return r;
    endfunction

    function automatic vec_t e0(vec_t r, int rob, int a, int c, logic ab, logic cb);
        r.e0v = 1; r.r0 = ROB_W'(rob); r.a0 = PRF_W'(a); r.c0 = PRF_W'(c);
        r.ab0 = ab; r.cb0 = cb;
        return r;
    endfunction

    function automatic vec_t e1(vec_t r, int rob, int a, int c, logic ab, logic cb);
        r.e1v = 1; r.r1 = ROB_W'(rob); r.a1 = PRF_W'(a); r.c1 = PRF_W'(c);
        r.ab1 = ab; r.cb1 = cb;
        return r;
    endfunction

    function automatic vec_t wbk(vec_t r, int k, int tag);
        if (k == 0) begin r.w0v = 1; r.w0 = PRF_W'(tag); end
        else begin r.w1v = 1; r.w1 = PRF_W'(tag); end
        return r;
    endfunction

    function automatic vec_t flsh(vec_t r);
        r.fl = 1;
        return r;
    endfunction

    // T is robid+7 and payload is robid, so issue data can be checked from xr
    task automatic apply(vec_t r);
        bus.flush_valid = r.fl;
        bus.iss_ready = r.rdy;
        bus.enq0_valid = r.e0v; bus.enq0_robid = r.r0;
        bus.enq0_T = PRF_W'(r.r0) + PRF_W'(7);
        bus.enq0_src1 = r.a0; bus.enq0_src2 = r.c0;
        bus.enq0_src1_busy = r.ab0; bus.enq0_src2_busy = r.cb0;
        bus.enq0_payload = 64'(r.r0);
        bus.enq1_valid = r.e1v; bus.enq1_robid = r.r1;
        bus.enq1_T = PRF_W'(r.r1) + PRF_W'(7);
        bus.enq1_src1 = r.a1; bus.enq1_src2 = r.c1;
        bus.enq1_src1_busy = r.ab1; bus.enq1_src2_busy = r.cb1;
        bus.enq1_payload = 64'(r.r1);
        bus.wb0_valid = r.w0v; bus.wb0_tag = r.w0;
        bus.wb1_valid = r.w1v; bus.wb1_tag = r.w1;
    endtask

    task automatic run_row(int n, vec_t r);
        apply(r);
        #2;
        chk($sformatf("row%0d_iss_valid", n), 64'(bus.iss_valid), 64'(r.xv));
        if (r.xv) begin
            chk($sformatf("row%0d_iss_robid", n), 64'(bus.iss_robid), 64'(r.xr));
            chk($sformatf("row%0d_iss_T", n), 64'(bus.iss_T),
                64'(PRF_W'(r.xr) + PRF_W'(7)));
            chk($sformatf("row%0d_iss_payload", n), bus.iss_payload, 64'(r.xr));
        end
        chk($sformatf("row%0d_left", n), 64'(bus.intisq_left), 64'(r.xl));
        chk($sformatf("row%0d_overflow", n), 64'(bus.overflow_err), 64'(r.xo));
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [ROB_W-1:0] rob;
        logic [PRF_W-1:0] t, s1, s2;
        logic b1, b2;
        logic [63:0] pay;
    } ment_t;

    ment_t mq[$];
    logic  movf;
    int    rc = 0;

    function automatic bit wbm(logic [PRF_W-1:0] tag);
        return (bus.wb0_valid && bus.wb0_tag == tag) ||
               (bus.wb1_valid && bus.wb1_tag == tag);
    endfunction

    function automatic bit mrdy(ment_t e);
`ifdef INTISQ_WAKEUP_BYPASS_EN
        return !(e.b1 && !wbm(e.s1)) && !(e.b2 && !wbm(e.s2));
`else
        return !e.b1 && !e.b2;
`endif
    endfunction

    function automatic int m_pick();
        foreach (mq[i]) if (mrdy(mq[i])) return i;
        return -1;
    endfunction

    task automatic do_reset();
        reset_n = 0;
        idle();
        mq.delete();
        movf = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic rnd_cycle(int pct);
        int pick, need, free_n, exp_left;
        bit ev;
        ment_t n;
        bus.flush_valid = ($urandom_range(0, 59) == 0);
        bus.iss_ready = ($urandom_range(0, 9) < 7);
        bus.enq0_valid = ($urandom_range(0, 99) < pct);
        bus.enq0_robid = ROB_W'(rc); bus.enq0_T = PRF_W'($urandom);
        bus.enq0_src1 = PRF_W'($urandom_range(0, 15));
        bus.enq0_src2 = PRF_W'($urandom_range(0, 15));
        bus.enq0_src1_busy = 1'($urandom_range(0, 1));
        bus.enq0_src2_busy = 1'($urandom_range(0, 1));
        bus.enq0_payload = {$urandom, $urandom};
        bus.enq1_valid = ($urandom_range(0, 99) < pct);
        bus.enq1_robid = ROB_W'(rc + 1); bus.enq1_T = PRF_W'($urandom);
        bus.enq1_src1 = PRF_W'($urandom_range(0, 15));
        bus.enq1_src2 = PRF_W'($urandom_range(0, 15));
        bus.enq1_src1_busy = 1'($urandom_range(0, 1));
        bus.enq1_src2_busy = 1'($urandom_range(0, 1));
        bus.enq1_payload = {$urandom, $urandom};
        bus.wb0_valid = 1'($urandom_range(0, 1));
        bus.wb0_tag = PRF_W'($urandom_range(0, 15));
        bus.wb1_valid = 1'($urandom_range(0, 1));
        bus.wb1_tag = PRF_W'($urandom_range(0, 15));
        rc += 2;
        #2;
        pick = m_pick();
        ev = (pick >= 0) && !bus.flush_valid;
        free_n = DEPTH - mq.size();
        exp_left = (free_n >= 2) ? 2 : free_n;
        chk("rnd_iss_valid", 64'(bus.iss_valid), 64'(ev));
        if (ev) begin
            chk("rnd_iss_robid", 64'(bus.iss_robid), 64'(mq[pick].rob));
            chk("rnd_iss_T", 64'(bus.iss_T), 64'(mq[pick].t));
            chk("rnd_iss_src1", 64'(bus.iss_src1), 64'(mq[pick].s1));
            chk("rnd_iss_src2", 64'(bus.iss_src2), 64'(mq[pick].s2));
            chk("rnd_iss_payload", bus.iss_payload, mq[pick].pay);
        end
        chk("rnd_left", 64'(bus.intisq_left), 64'(exp_left));
        chk("rnd_overflow", 64'(bus.overflow_err), 64'(movf));
        @(posedge clk);
        if (bus.flush_valid) begin
            mq.delete();
        end else begin
            need = int'(bus.enq0_valid) + int'(bus.enq1_valid);
            if (ev && bus.iss_ready) mq.delete(pick);
            foreach (mq[i]) begin
                if (wbm(mq[i].s1)) mq[i].b1 = 0;
                if (wbm(mq[i].s2)) mq[i].b2 = 0;
            end
            if (need > free_n) begin
                movf = 1;
            end else begin
                if (bus.enq0_valid) begin
                    n.rob = bus.enq0_robid; n.t = bus.enq0_T;
                    n.s1 = bus.enq0_src1; n.s2 = bus.enq0_src2;
                    n.b1 = bus.enq0_src1_busy && !wbm(bus.enq0_src1);
                    n.b2 = bus.enq0_src2_busy && !wbm(bus.enq0_src2);
                    n.pay = bus.enq0_payload;
                    mq.push_back(n);
                end
                if (bus.enq1_valid) begin
                    n.rob = bus.enq1_robid; n.t = bus.enq1_T;
                    n.s1 = bus.enq1_src1; n.s2 = bus.enq1_src2;
                    n.b1 = bus.enq1_src1_busy && !wbm(bus.enq1_src1);
                    n.b2 = bus.enq1_src2_busy && !wbm(bus.enq1_src2);
                    n.pay = bus.enq1_payload;
                    mq.push_back(n);
                end
            end
        end
        #1;
    endtask

    vec_t tq[$];

    initial begin
        // basic issue
        tq.push_back(rw(1, 0, 0, 2, 0));
        tq.push_back(e0(rw(1, 0, 0, 2, 0), 3, 4, 5, 0, 0));
        tq.push_back(rw(1, 1, 3, 2, 0));
        tq.push_back(rw(1, 0, 0, 2, 0));
        // ready B overtakes busy A, then A woken by wb0
        tq.push_back(e1(e0(rw(1, 0, 0, 2, 0), 1, 7, 8, 1, 0), 2, 3, 4, 0, 0));
        tq.push_back(rw(1, 1, 2, 2, 0));
        tq.push_back(wbk(rw(1, BYP, 1, 2, 0), 0, 7));
        tq.push_back(rw(1, !BYP, 1, 2, 0));
        tq.push_back(rw(1, 0, 0, 2, 0));
        // hold with iss_ready low
        tq.push_back(e1(e0(rw(0, 0, 0, 2, 0), 5, 1, 2, 0, 0), 6, 1, 2, 0, 0));
        tq.push_back(rw(0, 1, 5, 2, 0));
        tq.push_back(rw(0, 1, 5, 2, 0));
        tq.push_back(rw(0, 1, 5, 2, 0));
        tq.push_back(rw(1, 1, 5, 2, 0));
        tq.push_back(rw(1, 1, 6, 2, 0));
        tq.push_back(rw(1, 0, 0, 2, 0));
        // wakeup on wb1 in the enqueue cycle
        tq.push_back(wbk(e0(rw(1, 0, 0, 2, 0), 9, 11, 9, 0, 1), 1, 9));
        tq.push_back(rw(1, 1, 9, 2, 0));
        tq.push_back(rw(1, 0, 0, 2, 0));
        // fill, overflow, then drain in age order
        for (int k = 0; k < 4; k++)
            tq.push_back(e1(e0(rw(1, 0, 0, 2, 0), 20 + 2*k, 30, 31, 1, 0),
                            21 + 2*k, 30, 31, 1, 0));
        tq.push_back(rw(1, 0, 0, 0, 0));
        tq.push_back(e0(rw(1, 0, 0, 0, 0), 28, 30, 31, 1, 0));
        tq.push_back(rw(1, 0, 0, 0, 1));
        tq.push_back(wbk(rw(0, BYP, 20, 0, 1), 0, 30));
        for (int k = 0; k < 8; k++)
            tq.push_back(rw(1, 1, 20 + k, (k == 0) ? 0 : (k == 1) ? 1 : 2, 1));
        tq.push_back(rw(1, 0, 0, 2, 1));
        // flush with five entries, concurrent enqueue and ready
        tq.push_back(e1(e0(rw(1, 0, 0, 2, 1), 40, 50, 31, 1, 0), 41, 50, 31, 1, 0));
        tq.push_back(e1(e0(rw(1, 0, 0, 2, 1), 42, 50, 31, 1, 0), 43, 50, 31, 1, 0));
        tq.push_back(e0(rw(1, 0, 0, 2, 1), 44, 51, 52, 0, 0));
        tq.push_back(flsh(e0(rw(1, 0, 0, 2, 1), 45, 53, 54, 0, 0)));
        tq.push_back(rw(1, 0, 0, 2, 1));
        tq.push_back(rw(1, 0, 0, 2, 1));
        tq.push_back(e0(rw(1, 0, 0, 2, 1), 46, 60, 61, 0, 0));
        tq.push_back(rw(1, 1, 46, 2, 1));
        tq.push_back(rw(1, 0, 0, 2, 1));

        reset_n = 0;
        idle();
        #12;
        chk("reset_iss_valid", 64'(bus.iss_valid), 64'(0));
        chk("reset_left", 64'(bus.intisq_left), 64'(2));
        chk("reset_overflow", 64'(bus.overflow_err), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1;

        foreach (tq[i]) run_row(i, tq[i]);

        for (int p = 0; p < 6; p++) begin
            do_reset();
            for (int c = 0; c < 500; c++) rnd_cycle(10 + 15 * p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
